// File: rtl/dadda_pkg.sv
// dadda_pkg: shared mode type and elaboration helpers for the Dadda multiplier
package dadda_pkg;
  typedef enum logic {MODE_EXACT, MODE_APPROX} mult_mode_e;
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction
  function automatic int dadda_height(input int k);
    int d;
    d = 2;
    for (int i = 0; i < k; i++) d = d * 3 / 2;
    return d;
  endfunction
  function automatic int dadda_stages(input int h);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) if (dadda_height(i) < h) n = i + 1;
    return n;
  endfunction
endpackage

// File: rtl/dadda_reduce.sv
// dadda_reduce: Dadda column compression of a partial-product array to two rows, with OR-approximated low columns
module dadda_reduce import dadda_pkg::*; #(
  parameter int WIDTH = 6,
  parameter int APPROX_COLS = 4
) (
  input  logic [WIDTH-1:0]   pp [WIDTH],
  input  mult_mode_e         mode,
  output logic [2*WIDTH-2:0] row0,
  output logic [2*WIDTH-2:0] row1
);
  localparam int COLS = 2 * WIDTH - 1;
  localparam int STAGES = dadda_stages(WIDTH);
  logic apx;
`ifdef DADDA_APPROX_MODE_EN
  assign apx = mode == MODE_APPROX;
`else
  logic unused_mode;
  assign apx = 1'b0;
  assign unused_mode = mode == MODE_APPROX;
`endif
  logic [WIDTH+1:0] m [COLS+1];
  logic [WIDTH+1:0] n [COLS+1];
  int h [COLS+1];
  int nh [COLS+1];
  int d, k;
  logic c;
  logic [COLS-1:0] lo_or;
  // approximated columns are zeroed before reduction so they feed no carries upward
  always_comb begin
    m = '{default: '0};
    n = '{default: '0};
    h = '{default: 0};
    nh = '{default: 0};
    d = 0;
    k = 0;
    c = 1'b0;
    lo_or = '0;
    row0 = '0;
    row1 = '0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++) begin
        lo_or[i+j] = lo_or[i+j] | pp[i][j];
        m[i+j][h[i+j]] = pp[i][j] & !(apx && (i + j < APPROX_COLS));
        h[i+j]++;
      end
    for (int s = STAGES - 1; s >= 0; s--) begin
      d = dadda_height(s);
      n = '{default: '0};
      nh = '{default: 0};
      for (int j = 0; j < COLS; j++) begin
        k = 0;
        for (int t = 0; t < WIDTH; t++)
          if (h[j] - k + nh[j] > d && h[j] - k >= 2) begin
            if (h[j] - k + nh[j] == d + 1 || h[j] - k == 2) begin
              n[j][nh[j]] = m[j][k] ^ m[j][k+1];
              c = m[j][k] & m[j][k+1];
              k += 2;
            end else begin
              n[j][nh[j]] = m[j][k] ^ m[j][k+1] ^ m[j][k+2];
              c = (m[j][k] & m[j][k+1]) | (m[j][k+2] & (m[j][k] ^ m[j][k+1]));
              k += 3;
            end
            nh[j]++;
            n[j+1][nh[j+1]] = c;
            nh[j+1]++;
          end
        for (int t = 0; t < WIDTH; t++)
          if (t >= k && t < h[j]) begin
            n[j][nh[j]] = m[j][t];
            nh[j]++;
          end
      end
      m = n;
      h = nh;
    end
    for (int j = 0; j < COLS; j++) begin
      row0[j] = m[j][0] | (apx && j < APPROX_COLS && lo_or[j]);
      row1[j] = m[j][1];
    end
  end
endmodule

// File: rtl/dadda_mult_pipe.sv
// dadda_mult_pipe: 3-stage pipelined unsigned Dadda multiplier with valid/ready backpressure
// DADDA_APPROX_MODE_EN enables the runtime approximate mode; otherwise all products are exact
module dadda_mult_pipe import dadda_pkg::*; #(
  parameter int WIDTH = 6,
  parameter int APPROX_COLS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic                       approx,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [prod_w(WIDTH)-1:0]   prod,
  output logic                       prod_approx
);
  localparam int RW = prod_w(WIDTH) - 1;
  logic v1, v2, v3, adv1, adv2, adv3;
  logic [WIDTH-1:0] a1, b1;
  mult_mode_e mode_in, m1, m2;
  logic [WIDTH-1:0] pp [WIDTH];
  logic [RW-1:0] r0, r1, r0_q, r1_q, g, p;
  logic [RW:0] c;
  logic pr;
`ifdef DADDA_APPROX_MODE_EN
  assign mode_in = approx ? MODE_APPROX : MODE_EXACT;
`else
  logic unused_approx;
  assign mode_in = MODE_EXACT;
  assign unused_approx = approx;
`endif
  assign adv3 = !v3 || out_ready;
  assign adv2 = !v2 || adv3;
  assign adv1 = !v1 || adv2;
  assign in_ready = adv1;
  assign out_valid = v3;
  always_comb
    for (int i = 0; i < WIDTH; i++) pp[i] = a1 & {WIDTH{b1[i]}};
  dadda_reduce #(.WIDTH(WIDTH), .APPROX_COLS(APPROX_COLS)) u_reduce (
    .pp(pp), .mode(m1), .row0(r0), .row1(r1)
  );
  // flat carry-lookahead: each carry is a direct OR of generate terms gated by propagate runs
  always_comb begin
    g = r0_q & r1_q;
    p = r0_q ^ r1_q;
    c = '0;
    pr = 1'b0;
    for (int i = 0; i < RW; i++) begin
      c[i+1] = g[i];
      pr = p[i];
      for (int k = i - 1; k >= 0; k--) begin
        c[i+1] = c[i+1] | (pr & g[k]);
        pr = pr & p[k];
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      {v1, v2, v3} <= '0;
      a1 <= '0;
      b1 <= '0;
      m1 <= MODE_EXACT;
      m2 <= MODE_EXACT;
      r0_q <= '0;
      r1_q <= '0;
      prod <= '0;
      prod_approx <= 1'b0;
    end else begin
      if (adv1) v1 <= in_valid;
      if (adv1 && in_valid) begin
        a1 <= a;
        b1 <= b;
        m1 <= mode_in;
      end
      if (adv2) begin
        v2 <= v1;
        r0_q <= r0;
        r1_q <= r1;
        m2 <= m1;
      end
      if (adv3) begin
        v3 <= v2;
        prod <= {c[RW], p ^ c[RW-1:0]};
        prod_approx <= m2 == MODE_APPROX;
      end
    end
endmodule

// File: tb/tb_dadda_mult_pipe.sv
// tb_dadda_mult_pipe: randomized self-checking bench against a column-sum reference model
module tb_dadda_mult_pipe;
  localparam int W = 6;
  localparam int AC = 4;
`ifdef DADDA_APPROX_MODE_EN
  localparam bit APX_EN = 1'b1;
`else
  localparam bit APX_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, approx, out_valid, out_ready, prod_approx;
  logic [W-1:0] a, b;
  logic [2*W-1:0] prod;
  int checks = 0;
  int fails = 0;
  typedef struct {logic [2*W-1:0] p; logic m;} exp_t;
  exp_t q[$];

  dadda_mult_pipe #(.WIDTH(W), .APPROX_COLS(AC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .approx(approx), .out_valid(out_valid), .out_ready(out_ready), .prod(prod),
    .prod_approx(prod_approx)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic md);
    logic [2*W-1:0] r, lo;
    r = '0;
    lo = '0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (md && APX_EN && i + j < AC) lo[i+j] = lo[i+j] | (x[j] & y[i]);
        else if (x[j] & y[i]) r = r + ((2*W)'(1) << (i + j));
    return r + lo;
  endfunction

  task automatic run_one(input logic [W-1:0] x, input logic [W-1:0] y, input logic md,
                         output logic [2*W-1:0] pv, output logic pm, output int lat);
    @(posedge clk); #1;
    a = x; b = y; approx = md; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    pv = prod;
    pm = prod_approx;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; approx = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0d expected 0", out_valid); end
    checks++; if (prod !== '0) begin fails++; $display("FAIL reset_prod: got %0d expected 0", prod); end
    checks++; if (prod_approx !== 1'b0) begin fails++; $display("FAIL reset_prod_approx: got %0d expected 0", prod_approx); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0d expected 1", in_ready); end
  endtask

  task automatic test_exact();
    logic [2*W-1:0] pv; logic pm; int lat; logic [W-1:0] x, y;
    run_one(6'd63, 6'd63, 1'b0, pv, pm, lat);
    checks++; if (pv !== 12'd3969) begin fails++; $display("FAIL exact_63x63: got %0d expected 3969", pv); end
    checks++; if (pm !== 1'b0) begin fails++; $display("FAIL exact_tag: got %0d expected 0", pm); end
    checks++; if (lat != 3) begin fails++; $display("FAIL exact_latency: got %0d expected 3", lat); end
    for (int i = 0; i < 8; i++) begin
      x = W'($urandom); y = W'($urandom);
      run_one(x, y, 1'b0, pv, pm, lat);
      checks++; if (pv !== model(x, y, 1'b0) || lat != 3) begin
        fails++; $display("FAIL exact_rand %0d*%0d: got %0d lat %0d expected %0d lat 3", x, y, pv, lat, model(x, y, 1'b0));
      end
    end
  endtask

  task automatic test_approx();
    logic [2*W-1:0] pv; logic pm; int lat; logic [W-1:0] x, y;
    run_one(6'd63, 6'd63, 1'b1, pv, pm, lat);
    checks++; if (pv !== (APX_EN ? 12'd3935 : 12'd3969)) begin
      fails++; $display("FAIL approx_63x63: got %0d expected %0d", pv, APX_EN ? 3935 : 3969);
    end
    checks++; if (pm !== APX_EN) begin fails++; $display("FAIL approx_tag: got %0d expected %0d", pm, APX_EN); end
    for (int i = 0; i < 12; i++) begin
      x = W'($urandom); y = W'($urandom);
      run_one(x, y, 1'b1, pv, pm, lat);
      checks++; if (pv !== model(x, y, 1'b1) || pm !== APX_EN) begin
        fails++; $display("FAIL approx_rand %0d*%0d: got %0d tag %0d expected %0d tag %0d", x, y, pv, pm, model(x, y, 1'b1), APX_EN);
      end
    end
  endtask

  task automatic test_zero();
    logic [2*W-1:0] pv; logic pm; int lat;
    run_one(6'd0, 6'd45, 1'b0, pv, pm, lat);
    checks++; if (pv !== '0) begin fails++; $display("FAIL zero_exact: got %0d expected 0", pv); end
    run_one(6'd0, 6'd45, 1'b1, pv, pm, lat);
    checks++; if (pv !== '0) begin fails++; $display("FAIL zero_approx: got %0d expected 0", pv); end
    run_one(6'd45, 6'd0, 1'b1, pv, pm, lat);
    checks++; if (pv !== '0) begin fails++; $display("FAIL zero_approx_b: got %0d expected 0", pv); end
    run_one(6'd1, 6'd63, 1'b0, pv, pm, lat);
    checks++; if (pv !== 12'd63) begin fails++; $display("FAIL one_times_63: got %0d expected 63", pv); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] xa [5];
    logic [W-1:0] xb [5];
    logic [2*W-1:0] held;
    int sent, got, first;
    bit dropped, stalled;
    sent = 0; got = 0; first = -1; dropped = 0; stalled = 0; held = '0;
    q.delete();
    for (int i = 0; i < 5; i++) begin xa[i] = W'($urandom); xb[i] = W'($urandom); end
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(posedge clk); #1;
      if (out_valid && first < 0) first = c;
      out_ready = !(first >= 0 && c < first + 4);
      in_valid = sent < 5;
      a = xa[sent % 5]; b = xb[sent % 5]; approx = 1'b0;
      #1;
      checks++; if (in_ready !== ((sent - got) < 3 || out_ready)) begin
        fails++; $display("FAIL bp_in_ready cycle %0d: got %0d expected %0d", c, in_ready, (sent - got) < 3 || out_ready);
      end
      if (!in_ready) dropped = 1;
      if (out_valid && !out_ready) begin
        if (!stalled) held = prod;
        stalled = 1;
        checks++; if (prod !== held) begin fails++; $display("FAIL bp_stable: got %0d expected %0d", prod, held); end
      end
      if (out_valid && out_ready) begin
        checks++; if (q.size() == 0 || prod !== q[0].p) begin
          fails++; $display("FAIL bp_prod %0d: got %0d expected %0d", got, prod, q.size() ? q[0].p : 12'd0);
        end
        if (q.size()) void'(q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back('{model(a, b, 1'b0), 1'b0});
        sent++;
      end
    end
    checks++; if (got != 5 || !dropped || !stalled) begin
      fails++; $display("FAIL bp_summary: got %0d products dropped %0d stalled %0d expected 5 1 1", got, dropped, stalled);
    end
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset_midstream();
    int stale;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = W'($urandom); b = W'($urandom) | 6'd1; approx = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_full: got %0d expected 1", out_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || prod !== '0) begin
      fails++; $display("FAIL mid_reset: got valid %0d prod %0d expected 0 0", out_valid, prod);
    end
    rst = 1'b0; out_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    checks++; if (stale != 0) begin fails++; $display("FAIL mid_stale: got %0d outputs expected 0", stale); end
  endtask

  task automatic test_sweep();
    int sent, got, first, last;
    sent = 0; got = 0; first = -1; last = -1;
    q.delete();
    for (int c = 0; c < 4200 && got < 4096; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = sent < 4096; a = sent[5:0]; b = sent[11:6]; approx = 1'b0;
      #1;
      if (out_valid) begin
        checks++; if (q.size() == 0 || prod !== q[0].p) begin
          fails++; $display("FAIL sweep_prod %0d: got %0d expected %0d", got, prod, q.size() ? q[0].p : 12'd0);
        end
        if (q.size()) void'(q.pop_front());
        if (first < 0) first = c;
        last = c;
        got++;
      end
      if (in_valid) begin
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL sweep_in_ready cycle %0d: got %0d expected 1", c, in_ready); end
        q.push_back('{model(a, b, 1'b0), 1'b0});
        sent++;
      end
    end
    in_valid = 1'b0;
    checks++; if (got != 4096 || first != 3 || last != 4098) begin
      fails++; $display("FAIL sweep_throughput: got %0d first %0d last %0d expected 4096 3 4098", got, first, last);
    end
  endtask

  task automatic test_random_stream();
    int sent, got;
    sent = 0; got = 0;
    q.delete();
    for (int c = 0; c < 3000 && got < 300; c++) begin
      @(posedge clk); #1;
      in_valid = sent < 300 && ($urandom_range(3) != 0);
      out_ready = $urandom_range(9) < 7;
      a = W'($urandom); b = W'($urandom); approx = 1'($urandom);
      #1;
      checks++; if (in_ready !== ((sent - got) < 3 || out_ready)) begin
        fails++; $display("FAIL rand_in_ready cycle %0d: got %0d expected %0d", c, in_ready, (sent - got) < 3 || out_ready);
      end
      if (out_valid && out_ready) begin
        checks++; if (q.size() == 0 || prod !== q[0].p || prod_approx !== q[0].m) begin
          fails++; $display("FAIL rand_prod %0d: got %0d tag %0d expected %0d tag %0d", got, prod, prod_approx,
                            q.size() ? q[0].p : 12'd0, q.size() ? q[0].m : 1'b0);
        end
        if (q.size()) void'(q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back('{model(a, b, approx), approx & APX_EN});
        sent++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got != 300) begin fails++; $display("FAIL rand_count: got %0d expected 300", got); end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_approx();
    test_zero();
    test_backpressure();
    test_reset_midstream();
    test_sweep();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
